// File: rtl/turn_signal_flasher_if.sv
// Lever/button inputs and lamp/click outputs of the turn signal flasher.
// master = lever/lamp side (drives the levers); slave = flasher.
interface turn_signal_flasher_if;
    logic sw_left;
    logic sw_right;
    logic btn_hazard;
    logic turn_left;
    logic turn_right;
    logic hazard_on;
    logic click;

    modport master (
        output sw_left, sw_right, btn_hazard,
        input  turn_left, turn_right, hazard_on, click
    );

    modport slave (
        input  sw_left, sw_right, btn_hazard,
        output turn_left, turn_right, hazard_on, click
    );
endinterface

// File: rtl/turn_signal_flasher.sv
// Turn signal / hazard flasher: sync, debounce, request arbitration and blink timer.
// Optional tap-to-comfort-blink behaviour is enabled by defining COMFORT_BLINK_EN.
module turn_signal_flasher #(
    parameter int HALF_PERIOD     = 25000000,
    parameter int DEBOUNCE_CYC    = 500000,
    parameter int TAP_CYC         = 25000000,
    parameter int COMFORT_FLASHES = 3
) (
    input  logic                   clk,
    input  logic                   rst,
    turn_signal_flasher_if.slave   bus
);

    localparam int CW = $clog2(HALF_PERIOD);
    localparam int DW = $clog2(DEBOUNCE_CYC + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(HALF_PERIOD - 1);
    localparam logic [DW-1:0] DB_LAST  = DW'(DEBOUNCE_CYC - 1);

`ifdef COMFORT_BLINK_EN
    localparam int HW = $clog2(TAP_CYC + 1);
    localparam int FW = $clog2(COMFORT_FLASHES + 1);
    localparam logic [HW-1:0] TAP_SAT = HW'(TAP_CYC);
    localparam logic [FW-1:0] FL_LAST = FW'(COMFORT_FLASHES - 1);
    localparam logic [FW-1:0] FL_MAX  = FW'(COMFORT_FLASHES);
`endif

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEFT,
        S_RIGHT,
        S_HAZARD
`ifdef COMFORT_BLINK_EN
        ,
        S_COMFORT_L,
        S_COMFORT_R
`endif
    } state_t;

    logic [1:0]    r_sync_l, r_sync_r, r_sync_h;
    logic          w_l, w_r, w_h;
    logic          r_db, r_db_prev;
    logic [DW-1:0] r_db_cnt;
    logic          r_haz;
    logic          w_rise, w_haz_nxt;

    state_t        r_state, w_req, w_st_nxt;
    logic [CW-1:0] r_cnt, w_cnt_nxt;
    logic          r_phase, w_ph_nxt;
    logic          r_left, r_right, r_click;
    logic          w_left_nxt, w_right_nxt, w_click_nxt;
    logic          w_tc, w_cont;

`ifdef COMFORT_BLINK_EN
    logic [HW-1:0] r_hold, w_hold_nxt;
    logic [FW-1:0] r_flash, w_flash_nxt;
`else
    logic          w_unused_cfg;
    assign w_unused_cfg = ^{32'(TAP_CYC), 32'(COMFORT_FLASHES)};
`endif

    assign w_l = r_sync_l[1];
    assign w_r = r_sync_r[1];
    assign w_h = r_sync_h[1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync_l <= '0;
            r_sync_r <= '0;
            r_sync_h <= '0;
        end else begin
            r_sync_l <= {r_sync_l[0], bus.sw_left};
            r_sync_r <= {r_sync_r[0], bus.sw_right};
            r_sync_h <= {r_sync_h[0], bus.btn_hazard};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_db      <= 1'b0;
            r_db_cnt  <= '0;
            r_db_prev <= 1'b0;
            r_haz     <= 1'b0;
        end else begin
            r_db_prev <= r_db;
            r_haz     <= w_haz_nxt;
            if (w_h != r_db) begin
                if (r_db_cnt == DB_LAST) begin
                    r_db     <= w_h;
                    r_db_cnt <= '0;
                end else begin
                    r_db_cnt <= r_db_cnt + 1'b1;
                end
            end else begin
                r_db_cnt <= '0;
            end
        end
    end

    // Decode sees the post-toggle latch so a hazard press outranks a same-cycle lever change.
    assign w_rise    = r_db & ~r_db_prev;
    assign w_haz_nxt = r_haz ^ w_rise;

    always_comb begin
        w_tc        = (r_cnt == CNT_LAST);
        w_cont      = 1'b0;
        w_cnt_nxt   = r_cnt;
        w_ph_nxt    = r_phase;
        w_click_nxt = 1'b0;
        w_left_nxt  = 1'b0;
        w_right_nxt = 1'b0;

        if (w_haz_nxt)
            w_req = S_HAZARD;
        else if (w_l && !w_r)
            w_req = S_LEFT;
        else if (w_r && !w_l)
            w_req = S_RIGHT;
        else
            w_req = S_IDLE;
        w_st_nxt = w_req;

`ifdef COMFORT_BLINK_EN
        w_hold_nxt  = '0;
        w_flash_nxt = r_flash;
        if (w_req == S_IDLE && !w_l && !w_r) begin
            case (r_state)
                S_LEFT:      if (r_hold < TAP_SAT) w_st_nxt = S_COMFORT_L;
                S_RIGHT:     if (r_hold < TAP_SAT) w_st_nxt = S_COMFORT_R;
                S_COMFORT_L,
                S_COMFORT_R: w_st_nxt = r_state;
                default:     ;
            endcase
        end
        // Comfort inherits the running timer; it ends as the last ON phase closes.
        if (w_st_nxt == S_COMFORT_L || w_st_nxt == S_COMFORT_R) begin
            w_cont = 1'b1;
            if (r_flash >= FL_MAX || (w_tc && r_phase && r_flash >= FL_LAST))
                w_st_nxt = S_IDLE;
        end
`endif
        if (w_st_nxt == r_state)
            w_cont = 1'b1;

        if (w_st_nxt == S_IDLE) begin
            w_cnt_nxt = '0;
            w_ph_nxt  = 1'b0;
`ifdef COMFORT_BLINK_EN
            w_flash_nxt = '0;
`endif
        end else if (!w_cont) begin
            w_cnt_nxt   = '0;
            w_ph_nxt    = 1'b1;
            w_click_nxt = 1'b1;
`ifdef COMFORT_BLINK_EN
            w_flash_nxt = '0;
`endif
        end else if (w_tc) begin
            w_cnt_nxt   = '0;
            w_ph_nxt    = ~r_phase;
            w_click_nxt = 1'b1;
`ifdef COMFORT_BLINK_EN
            if (r_phase && r_flash < FL_MAX)
                w_flash_nxt = r_flash + 1'b1;
`endif
        end else begin
            w_cnt_nxt = r_cnt + 1'b1;
        end

`ifdef COMFORT_BLINK_EN
        if (w_st_nxt == S_LEFT || w_st_nxt == S_RIGHT) begin
            if (!w_cont)
                w_hold_nxt = HW'(1);
            else if (r_hold < TAP_SAT)
                w_hold_nxt = r_hold + 1'b1;
            else
                w_hold_nxt = r_hold;
        end
`endif

        case (w_st_nxt)
            S_LEFT:      w_left_nxt  = w_ph_nxt;
            S_RIGHT:     w_right_nxt = w_ph_nxt;
            S_HAZARD: begin
                w_left_nxt  = w_ph_nxt;
                w_right_nxt = w_ph_nxt;
            end
`ifdef COMFORT_BLINK_EN
            S_COMFORT_L: w_left_nxt  = w_ph_nxt;
            S_COMFORT_R: w_right_nxt = w_ph_nxt;
`endif
            default:     ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_phase <= 1'b0;
            r_left  <= 1'b0;
            r_right <= 1'b0;
            r_click <= 1'b0;
`ifdef COMFORT_BLINK_EN
            r_hold  <= '0;
            r_flash <= '0;
`endif
        end else begin
            r_state <= w_st_nxt;
            r_cnt   <= w_cnt_nxt;
            r_phase <= w_ph_nxt;
            r_left  <= w_left_nxt;
            r_right <= w_right_nxt;
            r_click <= w_click_nxt;
`ifdef COMFORT_BLINK_EN
            r_hold  <= w_hold_nxt;
            r_flash <= w_flash_nxt;
`endif
        end
    end

    assign bus.turn_left  = r_left;
    assign bus.turn_right = r_right;
    assign bus.hazard_on  = r_haz;
    assign bus.click      = r_click;

endmodule

// File: tb/tb_turn_signal_flasher.sv
module tb_turn_signal_flasher;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  turn_signal_flasher_if bus();

  turn_signal_flasher #(
    .HALF_PERIOD    (4),
    .DEBOUNCE_CYC   (3),
    .TAP_CYC        (10),
    .COMFORT_FLASHES(3)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         cyc;
    logic [3:0] exp;
    string      name;
  } exp_t;

  exp_t q[$];
  int n_pass  = 0;
  int n_total = 0;

  task automatic push(input int c, input logic [3:0] e, input string nm);
    exp_t x;
    x.cyc  = c;
    x.exp  = e;
    x.name = nm;
    q.push_back(x);
  endtask

  task automatic push_idle(input int c0, input int c1, input string nm);
    for (int c = c0; c <= c1; c++) push(c, 4'b0000, nm);
  endtask

  task automatic push_blink(input int start, input int k0, input int k1,
                            input int which, input logic haz, input string nm);
    for (int k = k0; k <= k1; k++) begin
      logic ph, ck, l, r;
      ph = ((k / 4) % 2) == 0;
      ck = (k % 4) == 0;
      l  = (which != 1) ? ph : 1'b0;
      r  = (which != 0) ? ph : 1'b0;
      push(start + k, {l, r, haz, ck}, nm);
    end
  endtask

  task automatic edges(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    exp_t       x;
    logic [3:0] act;
    act = {bus.turn_left, bus.turn_right, bus.hazard_on, bus.click};
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      x = q.pop_front();
      n_total++;
      if (x.cyc == cyc && act === x.exp)
        n_pass++;
      else
        $display("FAIL %s cyc=%0d got LRHC=%b expected=%b (due cyc %0d)",
                 x.name, cyc, act, x.exp, x.cyc);
    end
  end

  initial begin
    int a, b, d, f, g, j, k;
    bus.sw_left    = 1'b0;
    bus.sw_right   = 1'b0;
    bus.btn_hazard = 1'b0;

    edges(3);
    rst = 1'b0;

    edges(2);
    a = cyc;
    bus.sw_left = 1'b1;
    push_idle(a + 1, a + 2, "rst_pre_idle");
    push_blink(a + 3, 0, 1, 0, 1'b0, "rst_pre_blink");
    edges(5);
    rst = 1'b1;
    push(cyc, 4'b0000, "rst_async");
    #1;
    n_total++;
    if (bus.turn_left === 1'b0) n_pass++;
    else $display("FAIL rst_async_left got %b", bus.turn_left);
    n_total++;
    if (bus.turn_right === 1'b0) n_pass++;
    else $display("FAIL rst_async_right got %b", bus.turn_right);
    n_total++;
    if (bus.hazard_on === 1'b0) n_pass++;
    else $display("FAIL rst_async_hazard got %b", bus.hazard_on);
    n_total++;
    if (bus.click === 1'b0) n_pass++;
    else $display("FAIL rst_async_click got %b", bus.click);
    bus.sw_left = 1'b0;
    edges(3);
    rst = 1'b0;
    push_idle(cyc, cyc + 50, "post_rst_idle");
    edges(50);
    n_total++;
    if (bus.turn_left === 1'b0) n_pass++;
    else $display("FAIL quiet_left got %b", bus.turn_left);
    n_total++;
    if (bus.turn_right === 1'b0) n_pass++;
    else $display("FAIL quiet_right got %b", bus.turn_right);
    n_total++;
    if (bus.hazard_on === 1'b0) n_pass++;
    else $display("FAIL quiet_hazard got %b", bus.hazard_on);
    n_total++;
    if (bus.click === 1'b0) n_pass++;
    else $display("FAIL quiet_click got %b", bus.click);
    edges(1);

    b = cyc;
    bus.sw_left = 1'b1;
    push_idle(b + 1, b + 2, "left_latency");
    push_blink(b + 3, 0, 15, 0, 1'b0, "left_blink");
    edges(16);
    bus.sw_right = 1'b1;
    push_idle(cyc + 3, cyc + 5, "both_invalid");
    edges(6);
    d = cyc;
    bus.sw_left = 1'b0;
    push_idle(d + 1, d + 2, "right_latency");
    push_blink(d + 3, 0, 10, 1, 1'b0, "right_blink");
    edges(11);
    bus.sw_right = 1'b0;
    push_idle(cyc + 3, cyc + 5, "right_off");
    edges(8);

    f = cyc;
    bus.sw_left = 1'b1;
    push_idle(f + 1, f + 2, "left_h_latency");
    push_blink(f + 3, 0, 10, 0, 1'b0, "left_h_blink");
    edges(8);
    g = cyc;
    bus.btn_hazard = 1'b1;
    push_blink(g + 6, 0, 25, 2, 1'b1, "hazard_blink");
    edges(6);
    bus.btn_hazard = 1'b0;
    edges(8);
    bus.btn_hazard = 1'b1;
    edges(2);
    bus.btn_hazard = 1'b0;
    edges(4);
    bus.btn_hazard = 1'b1;
    edges(1);
    bus.btn_hazard = 1'b0;
    edges(5);
    bus.btn_hazard = 1'b1;
    push_blink(g + 32, 0, 12, 0, 1'b0, "left_resume");
    edges(6);
    bus.btn_hazard = 1'b0;
    edges(10);
    bus.sw_left = 1'b0;
    push_idle(g + 45, g + 47, "left_h_off");
    edges(10);

    j = cyc;
    bus.sw_left = 1'b1;
    push_idle(j + 1, j + 2, "tap_latency");
`ifdef COMFORT_BLINK_EN
    push_blink(j + 3, 0, 19, 0, 1'b0, "comfort_blink");
    push_idle(j + 23, j + 30, "comfort_end");
`else
    push_blink(j + 3, 0, 4, 0, 1'b0, "tap_blink");
    push_idle(j + 8, j + 30, "tap_release");
`endif
    edges(5);
    bus.sw_left = 1'b0;
    edges(30);

    k = cyc;
    bus.sw_left = 1'b1;
    push_idle(k + 1, k + 2, "long_latency");
    push_blink(k + 3, 0, 11, 0, 1'b0, "long_blink");
    push_idle(k + 15, k + 20, "long_release");
    edges(12);
    bus.sw_left = 1'b0;
    edges(12);

    while (q.size() > 0) begin
      exp_t x;
      x = q.pop_front();
      n_total++;
      $display("FAIL %s never sampled (due cyc %0d, expected=%b)", x.name, x.cyc, x.exp);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    if (n_pass == n_total && n_total > 0)
      $display("PASS");
    else
      $display("FAIL");
    $finish;
  end

endmodule
